current_pu_scheduler: RTL and testbench

CURRENT_PU_SCHEDULER -- requirements
Module: current_pu_scheduler

---
 rtl/current_pu_scheduler_pkg.sv | 27 ++
 rtl/current_pu_timeout_counter.sv | 47 ++++
 rtl/current_pu_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_current_pu_scheduler.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/current_pu_scheduler_pkg.sv
// rtl/current_pu_scheduler_pkg.sv - shared parameters, state encoding and helpers for the per-unit scheduler
// Purpose: project-wide defaults for data width, channel count and timeout,
//          plus the scheduler FSM state encoding.
// Ports:   none (package).
package current_pu_scheduler_pkg;

  localparam int PU_DATA_WIDTH     = 16;
  localparam int PU_CH_NUM         = 3;
  localparam int PU_TIMEOUT_CYCLES = 64;

  // The sample/shadow/output banks are tied to the three phase ports.
  localparam int PU_PHASE_NUM = 3;
  localparam int PU_IDX_W     = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } pu_state_e;

  // Counter width that can hold 0 .. n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/current_pu_timeout_counter.sv
// rtl/current_pu_timeout_counter.sv - wait-cycle counter that flags an overdue per-unit result
// Purpose: counts enabled cycles; expire_o is high in the enabled cycle that
//          would be the TIMEOUT_CYCLES-th consecutive one.
// Ports:
//   clk_i     : clock, rising edge
//   reset_ni  : synchronous active-low reset
//   clear_i   : return the count to zero (wins over enable_i)
//   enable_i  : count this cycle
//   expire_o  : combinational, enabled cycle with the count at TIMEOUT_CYCLES-1
module current_pu_timeout_counter
  import current_pu_scheduler_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = PU_TIMEOUT_CYCLES
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = enable_i && !clear_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/current_pu_scheduler.sv
// rtl/current_pu_scheduler.sv - sequences a phase-current triplet through one shared per-unit datapath
// Purpose: latches ia/ib/ic, issues them one at a time to the external
//          per-unit datapath, collects the results into shadow registers and
//          publishes all three together; aborts on a per-channel timeout.
// Ports:
//   sys_clk, reset_n                     : clock, synchronous active-low reset
//   sample_valid_in, ia_in, ib_in, ic_in : raw current triplet strobe and data
//   pu_value_valid_out, pu_value_out     : request to the per-unit datapath
//   pu_done_in, pu_result_in             : completion from the per-unit datapath
//   ia_pu_out, ib_pu_out, ic_pu_out      : per-unit currents, updated atomically
//   convert_done_out                     : strobe, outputs were just updated
//   busy_out                             : conversion in progress
//   timeout_err_out, overrun_err_out     : error strobes
module current_pu_scheduler
  import current_pu_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH     = PU_DATA_WIDTH,
  parameter int CH_NUM         = PU_CH_NUM,
  parameter int TIMEOUT_CYCLES = PU_TIMEOUT_CYCLES
) (
  input  logic                         sys_clk,
  input  logic                         reset_n,
  input  logic                         sample_valid_in,
  input  logic signed [DATA_WIDTH-1:0] ia_in,
  input  logic signed [DATA_WIDTH-1:0] ib_in,
  input  logic signed [DATA_WIDTH-1:0] ic_in,
  output logic                         pu_value_valid_out,
  output logic signed [DATA_WIDTH-1:0] pu_value_out,
  input  logic                         pu_done_in,
  input  logic signed [DATA_WIDTH-1:0] pu_result_in,
  output logic signed [DATA_WIDTH-1:0] ia_pu_out,
  output logic signed [DATA_WIDTH-1:0] ib_pu_out,
  output logic signed [DATA_WIDTH-1:0] ic_pu_out,
  output logic                         convert_done_out,
  output logic                         busy_out,
  output logic                         timeout_err_out,
  output logic                         overrun_err_out
);

  localparam logic [PU_IDX_W-1:0] LAST_IDX = PU_IDX_W'(CH_NUM - 1);

  typedef logic signed [DATA_WIDTH-1:0] word_t;

  pu_state_e state_q, state_d;
  logic [PU_IDX_W-1:0] idx_q, idx_d;

  word_t sample_q [PU_PHASE_NUM];
  word_t sample_d [PU_PHASE_NUM];
  word_t shadow_q [PU_PHASE_NUM];
  word_t shadow_d [PU_PHASE_NUM];
  word_t pu_out_q [PU_PHASE_NUM];
  word_t pu_out_d [PU_PHASE_NUM];

  logic convert_done_q, convert_done_d;
  logic timeout_err_q, timeout_err_d;
  logic overrun_err_q, overrun_err_d;

  word_t sample_sel;
  logic  tmo_clear;
  logic  tmo_enable;
  logic  tmo_expire;

  // Counter only runs while waiting; a done in the same cycle both clears it
  // and suppresses expiry, so a result landing on the last cycle still wins.
  assign tmo_enable = (state_q == ST_WAIT) && !pu_done_in;
  assign tmo_clear  = (state_q != ST_WAIT) || pu_done_in;

  current_pu_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (sys_clk),
    .reset_ni (reset_n),
    .clear_i  (tmo_clear),
    .enable_i (tmo_enable),
    .expire_o (tmo_expire)
  );

  always_comb begin
    sample_sel = '0;
    for (int i = 0; i < PU_PHASE_NUM; i++) begin
      if (idx_q == PU_IDX_W'(i)) begin
        sample_sel = sample_q[i];
      end
    end
  end

  always_comb begin
    state_d            = state_q;
    idx_d              = idx_q;
    sample_d           = sample_q;
    shadow_d           = shadow_q;
    pu_out_d           = pu_out_q;
    convert_done_d     = 1'b0;
    timeout_err_d      = 1'b0;
    // Any sample arriving outside IDLE is dropped and reported next cycle.
    overrun_err_d      = sample_valid_in && (state_q != ST_IDLE);
    pu_value_valid_out = 1'b0;
    pu_value_out       = '0;

    case (state_q)
      ST_IDLE: begin
        if (sample_valid_in) begin
          sample_d[0] = ia_in;
          sample_d[1] = ib_in;
          sample_d[2] = ic_in;
          idx_d       = '0;
          state_d     = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        pu_value_valid_out = 1'b1;
        pu_value_out       = sample_sel;
        state_d            = ST_WAIT;
      end

      ST_WAIT: begin
        if (pu_done_in) begin
          for (int i = 0; i < PU_PHASE_NUM; i++) begin
            if (idx_q == PU_IDX_W'(i)) begin
              shadow_d[i] = pu_result_in;
            end
          end
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + PU_IDX_W'(1);
            state_d = ST_ISSUE;
          end
        end else if (tmo_expire) begin
          // Partial shadow contents stay hidden; the next conversion
          // rewrites every channel before publishing.
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end

      ST_DONE: begin
        pu_out_d       = shadow_q;
        convert_done_d = 1'b1;
        state_d        = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      idx_q          <= '0;
      convert_done_q <= 1'b0;
      timeout_err_q  <= 1'b0;
      overrun_err_q  <= 1'b0;
      for (int i = 0; i < PU_PHASE_NUM; i++) begin
        sample_q[i] <= '0;
        shadow_q[i] <= '0;
        pu_out_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      convert_done_q <= convert_done_d;
      timeout_err_q  <= timeout_err_d;
      overrun_err_q  <= overrun_err_d;
      for (int i = 0; i < PU_PHASE_NUM; i++) begin
        sample_q[i] <= sample_d[i];
        shadow_q[i] <= shadow_d[i];
        pu_out_q[i] <= pu_out_d[i];
      end
    end
  end

  assign ia_pu_out        = pu_out_q[0];
  assign ib_pu_out        = pu_out_q[1];
  assign ic_pu_out        = pu_out_q[2];
  assign convert_done_out = convert_done_q;
  assign timeout_err_out  = timeout_err_q;
  assign overrun_err_out  = overrun_err_q;
  assign busy_out         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_current_pu_scheduler.sv
// tb/tb_current_pu_scheduler.sv - scoreboard bench for current_pu_scheduler with a behavioural datapath
module tb_current_pu_scheduler;

  localparam int DW  = 16;
  localparam int TMO = 64;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic                 reset_n;
  logic                 sample_valid_in;
  logic signed [DW-1:0] ia_in, ib_in, ic_in;
  logic                 pu_value_valid_out;
  logic signed [DW-1:0] pu_value_out;
  logic                 pu_done_in;
  logic signed [DW-1:0] pu_result_in;
  logic signed [DW-1:0] ia_pu_out, ib_pu_out, ic_pu_out;
  logic                 convert_done_out, busy_out, timeout_err_out, overrun_err_out;

  current_pu_scheduler dut (
    .sys_clk            (sys_clk),
    .reset_n            (reset_n),
    .sample_valid_in    (sample_valid_in),
    .ia_in              (ia_in),
    .ib_in              (ib_in),
    .ic_in              (ic_in),
    .pu_value_valid_out (pu_value_valid_out),
    .pu_value_out       (pu_value_out),
    .pu_done_in         (pu_done_in),
    .pu_result_in       (pu_result_in),
    .ia_pu_out          (ia_pu_out),
    .ib_pu_out          (ib_pu_out),
    .ic_pu_out          (ic_pu_out),
    .convert_done_out   (convert_done_out),
    .busy_out           (busy_out),
    .timeout_err_out    (timeout_err_out),
    .overrun_err_out    (overrun_err_out)
  );

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    int                   kind;   // 0 = convert_done, 1 = timeout
    logic signed [DW-1:0] a, b, c;
    int                   s;
    int                   lat;
  } exp_t;

  exp_t exp_q[$];
  int   exp_ovr = 0;
  logic signed [DW-1:0] mdl_a = '0, mdl_b = '0, mdl_c = '0;

  // datapath model controls
  int   lat = 1, dp_mode = 0, drop_ch = -1, req_idx = 0;
  bit   spur_issue = 1'b0;
  logic rsp_done = 1'b0, spur_done = 1'b0;
  logic signed [DW-1:0] rsp_res = '0, spur_res = '0;

  assign pu_done_in   = rsp_done | spur_done;
  assign pu_result_in = spur_done ? spur_res : rsp_res;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  function automatic logic signed [DW-1:0] dp_f(input int mode, input logic signed [DW-1:0] x);
    case (mode)
      0:       dp_f = DW'(x / 2);
      1:       dp_f = x;
      default: dp_f = ~x;
    endcase
  endfunction

  // External per-unit datapath: answers each request after lat cycles.
  initial begin
    bit pend;
    int cnt;
    logic signed [DW-1:0] pend_res;
    pend = 1'b0; cnt = 0; pend_res = '0;
    forever begin
      @(negedge sys_clk);
      rsp_done = 1'b0;
      if (!reset_n) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          if (cnt == 0) begin
            rsp_done = 1'b1;
            rsp_res  = pend_res;
            pend     = 1'b0;
          end else begin
            cnt--;
          end
        end
        if (pu_value_valid_out) begin
          if (req_idx != drop_ch) begin
            pend     = 1'b1;
            cnt      = lat;
            pend_res = dp_f(dp_mode, pu_value_out);
          end
          if (spur_issue) begin
            rsp_done = 1'b1;
            rsp_res  = pu_value_out ^ 16'sh1234;
          end
          req_idx++;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a strobe.
  initial begin
    exp_t e;
    logic signed [DW-1:0] pa, pb, pc;
    pa = '0; pb = '0; pc = '0;
    forever begin
      @(posedge sys_clk);
      #1;
      if (reset_n) begin
        if (ia_pu_out !== pa || ib_pu_out !== pb || ic_pu_out !== pc)
          chk("atomic_update", convert_done_out, 1);
        if (convert_done_out || timeout_err_out) begin
          chk("strobe_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("strobe_kind", timeout_err_out, e.kind);
            chk("strobe_latency", cyc + 1 - e.s, e.lat);
            chk("ia_pu_out", ia_pu_out, e.a);
            chk("ib_pu_out", ib_pu_out, e.b);
            chk("ic_pu_out", ic_pu_out, e.c);
          end
        end
        if (overrun_err_out) begin
          chk("overrun_expected", exp_ovr > 0, 1);
          if (exp_ovr > 0) exp_ovr--;
        end
      end
      pa = ia_pu_out; pb = ib_pu_out; pc = ic_pu_out;
    end
  end

  task automatic drive_sample(input logic signed [DW-1:0] a, b, c, output int s);
    @(negedge sys_clk);
    sample_valid_in = 1'b1;
    ia_in = a; ib_in = b; ic_in = c;
    req_idx = 0;
    @(negedge sys_clk);
    sample_valid_in = 1'b0;
    s = cyc;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    chk("drain_in_time", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic run_conv(input logic signed [DW-1:0] a, b, c, input int l, input int mode,
                          input int drop, input int ovr_k, input bit spur);
    exp_t e;
    int   s;
    int   to_ch;
    lat = l; dp_mode = mode; drop_ch = drop; spur_issue = spur;
    // A channel times out if it is never answered or needs more WAIT cycles than allowed.
    to_ch = (l + 1 > TMO) ? 0 : drop;
    drive_sample(a, b, c, s);
    e.s = s;
    if (to_ch >= 0) begin
      e.kind = 1; e.a = mdl_a; e.b = mdl_b; e.c = mdl_c;
      e.lat  = to_ch * (l + 2) + TMO + 2;
    end else begin
      e.kind = 0; e.a = dp_f(mode, a); e.b = dp_f(mode, b); e.c = dp_f(mode, c);
      e.lat  = 3 * (l + 2) + 2;
      mdl_a = e.a; mdl_b = e.b; mdl_c = e.c;
    end
    exp_q.push_back(e);
    if (ovr_k > 0) begin
      repeat (ovr_k - 1) @(negedge sys_clk);
      sample_valid_in = 1'b1;
      ia_in = DW'($urandom); ib_in = DW'($urandom); ic_in = DW'($urandom);
      exp_ovr++;
      @(negedge sys_clk);
      sample_valid_in = 1'b0;
    end
    wait_drain(3 * (l + 2) + TMO + 50);
    repeat (2) @(negedge sys_clk);
  endtask

  initial begin
    int s, n, l, drop, ovr, maxk;
    reset_n = 1'b0; sample_valid_in = 1'b0;
    ia_in = '0; ib_in = '0; ic_in = '0;
    repeat (3) @(negedge sys_clk);
    chk("reset_ia", ia_pu_out, 0);
    chk("reset_ib", ib_pu_out, 0);
    chk("reset_ic", ic_pu_out, 0);
    chk("reset_busy", busy_out, 0);
    chk("reset_strobes", {convert_done_out, timeout_err_out, overrun_err_out, pu_value_valid_out}, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // nominal conversion, halving datapath, L=20 -> latency 68
    run_conv(16'sd1000, -16'sd500, -16'sd500, 20, 0, -1, 0, 1'b0);
    // overrun 10 cycles into a conversion
    run_conv(16'sd100, 16'sd200, -16'sd300, 10, 1, -1, 10, 1'b0);
    // channel b never answered
    run_conv(16'sd7, 16'sd8, 16'sd9, 5, 0, 1, 0, 1'b0);
    chk("hold_after_timeout_ia", ia_pu_out, mdl_a);

    // spurious done while idle
    @(negedge sys_clk);
    spur_res = 16'sh7FFF; spur_done = 1'b1;
    @(negedge sys_clk);
    spur_done = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("spur_idle_ia", ia_pu_out, mdl_a);
    chk("spur_idle_busy", busy_out, 0);

    // reset during channel b WAIT
    lat = 20; dp_mode = 0; drop_ch = -1; spur_issue = 1'b0;
    drive_sample(16'sd300, -16'sd600, 16'sd900, s);
    n = 0;
    while (req_idx < 2 && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    chk("reach_ch_b", req_idx, 2);
    repeat (3) @(negedge sys_clk);
    reset_n = 1'b0;
    @(negedge sys_clk);
    mdl_a = '0; mdl_b = '0; mdl_c = '0;
    chk("midreset_ia", ia_pu_out, 0);
    chk("midreset_ic", ic_pu_out, 0);
    chk("midreset_busy", busy_out, 0);
    @(negedge sys_clk);
    reset_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    run_conv(-16'sd1234, 16'sd4321, 16'sd55, 3, 2, -1, 0, 1'b1);

    // bit-exact extremes through a passthrough datapath
    run_conv(16'sh8000, 16'sh7FFF, -16'sd1, 4, 1, -1, 0, 1'b0);
    chk("minneg_passthrough", ia_pu_out, -32768);

    // done on the last allowed WAIT cycle wins; one cycle later times out
    run_conv(16'sd11, 16'sd22, 16'sd33, TMO - 1, 1, -1, 0, 1'b0);
    run_conv(16'sd44, 16'sd55, 16'sd66, TMO, 1, -1, 0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      l    = $urandom_range(1, 30);
      drop = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 2)) : -1;
      maxk = (drop >= 0) ? drop * (l + 2) + TMO : 3 * (l + 2);
      ovr  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, maxk)) : 0;
      run_conv(DW'($urandom), DW'($urandom), DW'($urandom), l, $urandom_range(0, 2),
               drop, ovr, 1'($urandom_range(0, 1)));
    end

    repeat (4) @(negedge sys_clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("overrun_outstanding", exp_ovr, 0);
    chk("busy_idle_end", busy_out, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
